axi_mux_switch_ctrl: RTL and testbench

AXI_MUX_SWITCH_CTRL -- requirements
Module: axi_mux_switch_ctrl

---
 rtl/axi_mux_switch_ctrl_if.sv | 72 +++++++
 rtl/axi_mux_switch_ctrl.sv | 135 +++++++++++++
 tb/tb_axi_mux_switch_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mux_switch_ctrl_if.sv
// Soft-register request type and the AXI bus bundle used by the mux switch controller.
// Modports are named after the party they face: "master" sits opposite an AXI master.
package AxiMuxSwitchCtrlPkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;
endpackage

interface axi_bus_t #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport slave (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_mux_switch_ctrl.sv
// Sequences a downstream AXI mux select change: closes the address gates, waits for all
// outstanding traffic to drain, issues the held select write, then waits out the mux latency.
module axi_mux_switch_ctrl
    import AxiMuxSwitchCtrlPkg::*;
#(
    parameter logic [31:0] SR_ADDR = 32'h10,
    parameter int          CNT_W   = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  SoftRegReq sr_req,
    output SoftRegReq sr_req_out,
    axi_bus_t.master  axi_m,
    axi_bus_t.slave   axi_s,
    output logic      busy,
    output logic      drained
);

    typedef enum logic [2:0] {IDLE, DRAIN, ISSUE, SETTLE1, SETTLE2} SwitchState;

    SwitchState       state_q, state_d;
    logic [63:0]      hold_q, hold_d;
    logic [CNT_W-1:0] rdCnt_q, awCnt_q, wbCnt_q;
    logic             arBlock, awBlock;
    logic             arAccept, awAccept, rLastBeat, wLastBeat, bHandshake;
    logic             selWrite;

    // A decrement at zero is a protocol error and leaves the counter at zero.
    function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + CNT_W'(1);
        if (dec && !inc && cnt != '0)
            return cnt - CNT_W'(1);
        return cnt;
    endfunction

    assign axi_s.arid    = axi_m.arid;
    assign axi_s.araddr  = axi_m.araddr;
    assign axi_s.arlen   = axi_m.arlen;
    assign axi_s.arsize  = axi_m.arsize;
    assign axi_s.arburst = axi_m.arburst;
    assign axi_s.arvalid = axi_m.arvalid & ~arBlock;
    assign axi_m.arready = axi_s.arready & ~arBlock;
    assign axi_s.awid    = axi_m.awid;
    assign axi_s.awaddr  = axi_m.awaddr;
    assign axi_s.awlen   = axi_m.awlen;
    assign axi_s.awsize  = axi_m.awsize;
    assign axi_s.awburst = axi_m.awburst;
    assign axi_s.awvalid = axi_m.awvalid & ~awBlock;
    assign axi_m.awready = axi_s.awready & ~awBlock;
    assign axi_s.wdata   = axi_m.wdata;
    assign axi_s.wstrb   = axi_m.wstrb;
    assign axi_s.wlast   = axi_m.wlast;
    assign axi_s.wvalid  = axi_m.wvalid;
    assign axi_m.wready  = axi_s.wready;
    assign axi_m.bid     = axi_s.bid;
    assign axi_m.bresp   = axi_s.bresp;
    assign axi_m.bvalid  = axi_s.bvalid;
    assign axi_s.bready  = axi_m.bready;
    assign axi_m.rid     = axi_s.rid;
    assign axi_m.rdata   = axi_s.rdata;
    assign axi_m.rresp   = axi_s.rresp;
    assign axi_m.rlast   = axi_s.rlast;
    assign axi_m.rvalid  = axi_s.rvalid;
    assign axi_s.rready  = axi_m.rready;

    assign arAccept   = axi_s.arvalid & axi_s.arready;
    assign awAccept   = axi_s.awvalid & axi_s.awready;
    assign rLastBeat  = axi_s.rvalid & axi_s.rready & axi_s.rlast;
    assign wLastBeat  = axi_s.wvalid & axi_s.wready & axi_s.wlast;
    assign bHandshake = axi_s.bvalid & axi_s.bready;
    assign selWrite   = sr_req.valid & sr_req.isWrite & (sr_req.addr == SR_ADDR);
    assign drained    = (rdCnt_q == '0) && (awCnt_q == '0) && (wbCnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdCnt_q <= '0;
            awCnt_q <= '0;
            wbCnt_q <= '0;
        end else begin
            rdCnt_q <= nextCount(rdCnt_q, arAccept, rLastBeat);
            awCnt_q <= nextCount(awCnt_q, awAccept, wLastBeat);
            wbCnt_q <= nextCount(wbCnt_q, wLastBeat, bHandshake);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Select writes are only taken in IDLE and DRAIN; later ones are dropped.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (selWrite) begin
                    state_d = DRAIN;
                    hold_d  = sr_req.data;
                end
            end
            DRAIN: begin
                if (selWrite)
                    hold_d = sr_req.data;
                if (drained)
                    state_d = ISSUE;
            end
            ISSUE:   state_d = SETTLE1;
            SETTLE1: state_d = SETTLE2;
            SETTLE2: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_req_out = '0;
        busy       = (state_q != IDLE);
        arBlock    = busy || (&rdCnt_q);
        awBlock    = busy || (&awCnt_q) || (&wbCnt_q);
        if (state_q == ISSUE) begin
            sr_req_out.valid   = 1'b1;
            sr_req_out.isWrite = 1'b1;
            sr_req_out.addr    = SR_ADDR;
            sr_req_out.data    = hold_q;
        end
    end

endmodule

// File: tb/tb_axi_mux_switch_ctrl.sv
// Directed bench for the mux switch controller; counters are 2 bits wide so the
// all-ones blocking point is reachable with three outstanding reads.
module tb_axi_mux_switch_ctrl;
    import AxiMuxSwitchCtrlPkg::*;

    localparam logic [31:0] SEL_ADDR = 32'h10;

    logic      clk;
    logic      rst;
    SoftRegReq srReq;
    SoftRegReq srOut;
    logic      busy;
    logic      drained;
    int        assertCount;
    int        failCount;

    axi_bus_t mIf ();
    axi_bus_t sIf ();

    axi_mux_switch_ctrl #(.SR_ADDR(SEL_ADDR), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sr_req     (srReq),
        .sr_req_out (srOut),
        .axi_m      (mIf),
        .axi_s      (sIf),
        .busy       (busy),
        .drained    (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic isWrite, input logic [63:0] data);
        srReq.valid   = 1'b1;
        srReq.isWrite = isWrite;
        srReq.addr    = addr;
        srReq.data    = data;
    endtask

    task automatic clearStimulus();
        srReq = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        srReq = '0;
        mIf.arid = '0; mIf.araddr = '0; mIf.arlen = '0; mIf.arsize = 3'd3; mIf.arburst = 2'b01;
        mIf.arvalid = 1'b0;
        mIf.awid = '0; mIf.awaddr = '0; mIf.awlen = '0; mIf.awsize = 3'd3; mIf.awburst = 2'b01;
        mIf.awvalid = 1'b0;
        mIf.wdata = '0; mIf.wstrb = '1; mIf.wlast = 1'b0; mIf.wvalid = 1'b0;
        mIf.bready = 1'b1;
        mIf.rready = 1'b1;
        sIf.arready = 1'b1;
        sIf.awready = 1'b1;
        sIf.wready  = 1'b1;
        sIf.bid = '0; sIf.bresp = '0; sIf.bvalid = 1'b0;
        sIf.rid = '0; sIf.rdata = '0; sIf.rresp = '0; sIf.rlast = 1'b0; sIf.rvalid = 1'b0;

        // Reset state
        repeat (2) tick();
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_drained", 64'(drained), 64'(1));
        checkOutput("reset_out_valid", 64'(srOut.valid), 64'(0));
        checkOutput("reset_arready", 64'(mIf.arready), 64'(1));
        checkOutput("reset_awready", 64'(mIf.awready), 64'(1));
        checkOutput("reset_hold", dut.hold_q, 64'(0));
        rst = 1'b0;
        tick();

        // Pass-through fields
        mIf.araddr = 32'h1234_5678;
        mIf.wdata  = 64'hA5A5_0000_FFFF_0001;
        sIf.rdata  = 64'hDEAD_BEEF_0000_0001;
        sIf.bresp  = 2'b10;
        #1;
        checkOutput("pass_araddr", 64'(sIf.araddr), 64'h1234_5678);
        checkOutput("pass_wdata", sIf.wdata, 64'hA5A5_0000_FFFF_0001);
        checkOutput("pass_rdata", mIf.rdata, 64'hDEAD_BEEF_0000_0001);
        checkOutput("pass_bresp", 64'(mIf.bresp), 64'(2'b10));

        // Idle switch: DRAIN at T+1, ISSUE at T+2, IDLE at T+5
        applyStimulus(SEL_ADDR, 1'b1, 64'h0);
        tick();
        clearStimulus();
        #1;
        checkOutput("idle_t1_busy", 64'(busy), 64'(1));
        checkOutput("idle_t1_valid", 64'(srOut.valid), 64'(0));
        checkOutput("idle_t1_gate", 64'(mIf.arready), 64'(0));
        tick();
        checkOutput("idle_t2_valid", 64'(srOut.valid), 64'(1));
        checkOutput("idle_t2_write", 64'(srOut.isWrite), 64'(1));
        checkOutput("idle_t2_addr", 64'(srOut.addr), 64'(SEL_ADDR));
        checkOutput("idle_t2_data", srOut.data, 64'h0);
        tick();
        checkOutput("idle_t3_valid", 64'(srOut.valid), 64'(0));
        checkOutput("idle_t3_busy", 64'(busy), 64'(1));
        tick();
        checkOutput("idle_t4_busy", 64'(busy), 64'(1));
        tick();
        checkOutput("idle_t5_busy", 64'(busy), 64'(0));
        checkOutput("idle_t5_gate", 64'(mIf.arready), 64'(1));

        // Non-matching address and soft-register reads never start a switch
        applyStimulus(32'h14, 1'b1, 64'h5);
        tick();
        checkOutput("nomatch_addr_busy", 64'(busy), 64'(0));
        applyStimulus(SEL_ADDR, 1'b0, 64'h5);
        tick();
        clearStimulus();
        #1;
        checkOutput("nomatch_read_busy", 64'(busy), 64'(0));
        checkOutput("nomatch_valid", 64'(srOut.valid), 64'(0));

        // Drain read: one AR of four beats outstanding
        mIf.arvalid = 1'b1;
        mIf.arlen   = 8'd3;
        #1;
        checkOutput("dread_ar_pass", 64'(sIf.arvalid), 64'(1));
        tick();
        mIf.arvalid = 1'b0;
        #1;
        checkOutput("dread_not_drained", 64'(drained), 64'(0));
        applyStimulus(SEL_ADDR, 1'b1, 64'h5);
        tick();
        clearStimulus();
        mIf.arvalid = 1'b1;
        #1;
        checkOutput("dread_ar_blocked", 64'(sIf.arvalid), 64'(0));
        checkOutput("dread_arready_blocked", 64'(mIf.arready), 64'(0));
        checkOutput("dread_busy", 64'(busy), 64'(1));
        sIf.rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sIf.rlast = (i == 3);
            #1;
            checkOutput($sformatf("dread_beat%0d_valid", i), 64'(srOut.valid), 64'(0));
            checkOutput($sformatf("dread_beat%0d_gate", i), 64'(mIf.arready), 64'(0));
            tick();
        end
        sIf.rvalid = 1'b0;
        sIf.rlast  = 1'b0;
        #1;
        checkOutput("dread_drained", 64'(drained), 64'(1));
        checkOutput("dread_still_held", 64'(srOut.valid), 64'(0));
        tick();
        checkOutput("dread_issue_valid", 64'(srOut.valid), 64'(1));
        checkOutput("dread_issue_data", srOut.data, 64'h5);
        checkOutput("dread_issue_gate", 64'(sIf.arvalid), 64'(0));
        repeat (3) tick();
        checkOutput("dread_reopen_arvalid", 64'(sIf.arvalid), 64'(1));
        checkOutput("dread_reopen_arready", 64'(mIf.arready), 64'(1));
        tick();
        mIf.arvalid = 1'b0;
        sIf.rvalid  = 1'b1;
        sIf.rlast   = 1'b1;
        tick();
        sIf.rvalid = 1'b0;
        sIf.rlast  = 1'b0;
        #1;
        checkOutput("dread_final_drained", 64'(drained), 64'(1));

        // Drain write: B held back for 10 cycles
        mIf.awvalid = 1'b1;
        tick();
        mIf.awvalid = 1'b0;
        applyStimulus(SEL_ADDR, 1'b1, 64'h7);
        tick();
        clearStimulus();
        mIf.wvalid = 1'b1;
        mIf.wlast  = 1'b0;
        #1;
        checkOutput("dwrite_busy", 64'(busy), 64'(1));
        checkOutput("dwrite_aw_gate", 64'(mIf.awready), 64'(0));
        tick();
        mIf.wlast = 1'b1;
        tick();
        mIf.wvalid = 1'b0;
        mIf.wlast  = 1'b0;
        #1;
        checkOutput("dwrite_awcnt", 64'(dut.awCnt_q), 64'(0));
        checkOutput("dwrite_wbcnt", 64'(dut.wbCnt_q), 64'(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("dwrite_wait%0d_wbcnt", i), 64'(dut.wbCnt_q), 64'(1));
            checkOutput($sformatf("dwrite_wait%0d_valid", i), 64'(srOut.valid), 64'(0));
        end
        sIf.bvalid = 1'b1;
        tick();
        sIf.bvalid = 1'b0;
        #1;
        checkOutput("dwrite_drained", 64'(drained), 64'(1));
        checkOutput("dwrite_held", 64'(srOut.valid), 64'(0));
        tick();
        checkOutput("dwrite_issue_valid", 64'(srOut.valid), 64'(1));
        checkOutput("dwrite_issue_data", srOut.data, 64'h7);
        repeat (3) tick();
        checkOutput("dwrite_idle", 64'(busy), 64'(0));

        // Overwrite during DRAIN, and a write during ISSUE is dropped
        mIf.arvalid = 1'b1;
        tick();
        mIf.arvalid = 1'b0;
        applyStimulus(SEL_ADDR, 1'b1, 64'h3);
        tick();
        applyStimulus(SEL_ADDR, 1'b1, 64'h1);
        tick();
        applyStimulus(SEL_ADDR, 1'b1, 64'h0);
        tick();
        clearStimulus();
        #1;
        checkOutput("ovr_hold", dut.hold_q, 64'h0);
        checkOutput("ovr_busy", 64'(busy), 64'(1));
        checkOutput("ovr_held", 64'(srOut.valid), 64'(0));
        sIf.rvalid = 1'b1;
        sIf.rlast  = 1'b1;
        tick();
        sIf.rvalid = 1'b0;
        sIf.rlast  = 1'b0;
        #1;
        checkOutput("ovr_drain_valid", 64'(srOut.valid), 64'(0));
        tick();
        checkOutput("ovr_issue_valid", 64'(srOut.valid), 64'(1));
        checkOutput("ovr_issue_data", srOut.data, 64'h0);
        applyStimulus(SEL_ADDR, 1'b1, 64'h9);
        tick();
        clearStimulus();
        #1;
        checkOutput("ovr_s1_valid", 64'(srOut.valid), 64'(0));
        tick();
        checkOutput("ovr_s2_valid", 64'(srOut.valid), 64'(0));
        tick();
        checkOutput("ovr_idle_busy", 64'(busy), 64'(0));
        tick();
        checkOutput("ovr_dropped_busy", 64'(busy), 64'(0));
        checkOutput("ovr_dropped_valid", 64'(srOut.valid), 64'(0));

        // Saturation: three outstanding reads close the AR gate
        mIf.arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("sat_accept%0d", i), 64'(mIf.arready), 64'(1));
            tick();
        end
        #1;
        checkOutput("sat_full_arready", 64'(mIf.arready), 64'(0));
        checkOutput("sat_full_arvalid", 64'(sIf.arvalid), 64'(0));
        checkOutput("sat_full_cnt", 64'(dut.rdCnt_q), 64'(3));
        tick();
        checkOutput("sat_hold_arready", 64'(mIf.arready), 64'(0));
        sIf.rvalid = 1'b1;
        sIf.rlast  = 1'b1;
        #1;
        checkOutput("sat_rlast_arready", 64'(mIf.arready), 64'(0));
        mIf.arvalid = 1'b0;
        tick();
        sIf.rvalid = 1'b0;
        #1;
        checkOutput("sat_reopen_arready", 64'(mIf.arready), 64'(1));
        checkOutput("sat_reopen_cnt", 64'(dut.rdCnt_q), 64'(2));
        mIf.arvalid = 1'b1;
        sIf.rvalid  = 1'b1;
        tick();
        mIf.arvalid = 1'b0;
        sIf.rvalid  = 1'b0;
        #1;
        checkOutput("simul_incdec_cnt", 64'(dut.rdCnt_q), 64'(2));
        sIf.rvalid = 1'b1;
        repeat (2) tick();
        sIf.rvalid = 1'b0;
        #1;
        checkOutput("sat_drained", 64'(drained), 64'(1));
        sIf.rvalid = 1'b1;
        tick();
        sIf.rvalid = 1'b0;
        sIf.rlast  = 1'b0;
        #1;
        checkOutput("underflow_cnt", 64'(dut.rdCnt_q), 64'(0));
        checkOutput("underflow_arready", 64'(mIf.arready), 64'(1));

        // Reset mid-DRAIN discards the pending switch
        mIf.arvalid = 1'b1;
        tick();
        mIf.arvalid = 1'b0;
        applyStimulus(SEL_ADDR, 1'b1, 64'h4);
        tick();
        clearStimulus();
        #1;
        checkOutput("rstdrain_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        checkOutput("rstdrain_busy", 64'(busy), 64'(0));
        checkOutput("rstdrain_drained", 64'(drained), 64'(1));
        checkOutput("rstdrain_arready", 64'(mIf.arready), 64'(1));
        checkOutput("rstdrain_hold", dut.hold_q, 64'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("rstdrain_after%0d_valid", i), 64'(srOut.valid), 64'(0));
            checkOutput($sformatf("rstdrain_after%0d_busy", i), 64'(busy), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
